inst_fetch_resp: RTL and testbench

- Instruction-memory responder: the far end of the fetch interface driven by the PC generator's pc/ce outputs.
- Samples a fetch request (ce, addr) and returns the 32-bit instruction word after a programmable number of wait states, with a one-cycle valid strobe.
- Also provides a word-wide program-load (writer) port, so testbenches and the boot path can fill the memory.
- Flags misaligned and out-of-range fetches.

---
 rtl/inst_fetch_resp_pkg.sv | 22 ++
 rtl/inst_mem_array.sv | 24 ++
 rtl/inst_fetch_resp.sv | 102 ++++++++++
 tb/tb_inst_fetch_resp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_resp_pkg;

  localparam int          INST_MEM_LOG2 = 10;
  localparam int          INST_MEM_NUM  = 1 << INST_MEM_LOG2;
  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic [31:0] NOP_INST      = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A fetch is refused when it is not word aligned or points past the array.
  function automatic logic addr_fault(input logic [31:0] a, input int log2);
    return (a[1:0] != 2'b00) || ((a >> (log2 + 2)) != ZERO_WORD);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port.
// Latency: read data appears the cycle after re; holds while re is low.
// Backpressure: none; both ports accept every cycle.
module inst_mem_array #(
  parameter int MEM_LOG2 = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [MEM_LOG2-1:0] waddr,
  input  logic [31:0]         wdata,
  input  logic                re,
  input  logic [MEM_LOG2-1:0] raddr,
  output logic [31:0]         rdata
);

  logic [31:0] mem [1 << MEM_LOG2];

  // Nonblocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-memory responder for the PC generator's fetch requests, plus a program-load port.
// Latency: inst_valid strobes WAIT_CYCLES+1 cycles after the edge that samples ce.
// Backpressure: busy is high during wait states and ce is ignored then.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int MEM_LOG2    = INST_MEM_LOG2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [31:0]         addr,
  output logic [31:0]         inst,
  output logic                inst_valid,
  output logic                fault,
  output logic                busy,
  input  logic                ld_we,
  input  logic [MEM_LOG2-1:0] ld_addr,
  input  logic [31:0]         ld_data
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        nop_q;
  logic        accept;
  logic        rd_go;
  logic        rd_fault;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] mem_rdata;

  assign accept = ce && (state != ST_WAIT);

  // With no wait states the read happens on the sampling edge, straight from addr.
  always_comb begin
    rd_addr  = (state == ST_WAIT) ? addr_q : addr;
    rd_go    = ZERO_WAIT ? accept : ((state == ST_WAIT) && (cnt == 4'd1));
    rd_fault = addr_fault(rd_addr, MEM_LOG2);
    rd_en    = rd_go && !rd_fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ce) state_nxt = ZERO_WAIT ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: begin
        if (ce) state_nxt = ZERO_WAIT ? ST_RESP : ST_WAIT;
        else    state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    inst_valid = (state == ST_RESP);
    busy       = (state == ST_WAIT);
    fault      = inst_valid && nop_q;
    inst       = nop_q ? NOP_INST : mem_rdata;
  end

  // nop_q selects the NOP word after a fault and after reset, so inst reads 0
  // without resetting the memory read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 4'd0;
      addr_q <= ZERO_WORD;
      nop_q  <= 1'b1;
    end else begin
      if (accept) begin
        addr_q <= addr;
        cnt    <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_go) nop_q <= rd_fault;
    end
  end

  inst_mem_array #(
    .MEM_LOG2(MEM_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (ld_we && !rst),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (rd_addr[MEM_LOG2+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: four instances with 1, 0, 2 and 3 wait states against a word-array model.
module tb_inst_fetch_resp;

  logic        clk;
  logic        rst;
  logic [3:0]  ce;
  logic [31:0] addr;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] inst_w [4];
  logic [3:0]  iv_w;
  logic [3:0]  fault_w;
  logic [3:0]  busy_w;

  logic [31:0] mem_m [1024];
  logic [31:0] last_inst [4];
  logic [31:0] sq [$];
  int          n_chk;
  int          n_pass;
  int          n_fail;

  inst_fetch_resp #(.MEM_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .ce(ce[0]), .addr(addr), .inst(inst_w[0]), .inst_valid(iv_w[0]),
    .fault(fault_w[0]), .busy(busy_w[0]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_fetch_resp #(.MEM_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .ce(ce[1]), .addr(addr), .inst(inst_w[1]), .inst_valid(iv_w[1]),
    .fault(fault_w[1]), .busy(busy_w[1]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_fetch_resp #(.MEM_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .ce(ce[2]), .addr(addr), .inst(inst_w[2]), .inst_valid(iv_w[2]),
    .fault(fault_w[2]), .busy(busy_w[2]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_fetch_resp #(.MEM_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .ce(ce[3]), .addr(addr), .inst(inst_w[3]), .inst_valid(iv_w[3]),
    .fault(fault_w[3]), .busy(busy_w[3]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int w_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  // {valid, busy, fault, inst}
  function automatic logic [34:0] obs(input int k);
    return {iv_w[k], busy_w[k], fault_w[k], inst_w[k]};
  endfunction

  // Expected {fault, inst} for a fetch of byte address a from the model memory.
  function automatic logic [32:0] model(input logic [31:0] a);
    if ((a % 4) != 0 || a >= 32'h0000_1000) return {1'b1, 32'h0};
    return {1'b0, mem_m[a[11:2]]};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return {20'h0, r[9:0], (r[11:10] == 2'b00) ? 2'b01 : r[11:10]};
      1:       return {r[31:12] | 20'h1, r[11:2], 2'b00};
      2:       return 32'hFFFF_FFFC;
      default: return {20'h0, r[9:0], 2'b00};
    endcase
  endfunction

  task automatic check(input string tag, input logic [34:0] o, input logic [34:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
    mem_m[idx] = d;
  endtask

  // Issues the addresses in sq to instance k back to back, holding ce through each response.
  task automatic burst(input int k);
    int          w;
    logic [32:0] m;
    w = w_of(k);
    @(negedge clk);
    ce[k] = 1'b1;
    addr  = sq[0];
    @(posedge clk);
    for (int i = 0; i < sq.size(); i++) begin
      m = model(sq[i]);
      for (int j = 0; j < w; j++) begin
        #1;
        if (j == 0) addr = $urandom;
        check($sformatf("wait_k%0d_a%h", k, sq[i]), obs(k), {3'b010, last_inst[k]});
        @(posedge clk);
      end
      #1;
      last_inst[k] = m[31:0];
      check($sformatf("resp_k%0d_a%h", k, sq[i]), obs(k), {1'b1, 1'b0, m[32], m[31:0]});
      if (i + 1 < sq.size()) addr = sq[i + 1];
      else ce[k] = 1'b0;
      @(posedge clk);
    end
    #1;
    check($sformatf("idle_k%0d", k), obs(k), {3'b000, last_inst[k]});
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; ce = 4'b0; addr = 32'h0;
    ld_we = 1'b0; ld_addr = 10'h0; ld_data = 32'h0;
    for (int k = 0; k < 4; k++) last_inst[k] = 32'h0;

    // Reset state, then idle with ce low.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("reset_k%0d", k), obs(k), 35'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) check($sformatf("noce_k%0d", k), obs(k), 35'h0);
    end

    // Program load: words 0..3 fixed, the rest random.
    for (int i = 0; i < 1024; i++)
      load(i, (i < 4) ? 32'h1111_1111 * (i + 1) : $urandom);

    // Single fetch with one wait state.
    sq = '{32'h8};
    burst(0);

    // Streaming with no wait states.
    sq = '{32'h0, 32'h4, 32'h8, 32'hC};
    burst(1);

    // Faults, then a good fetch.
    sq = '{32'h6};          burst(0);
    sq = '{32'h0000_1000};  burst(0);
    sq = '{32'hFFFF_FFFC};  burst(0);
    sq = '{32'h0};          burst(0);
    sq = '{32'h6, 32'h4, 32'h0000_1000, 32'h0}; burst(1);

    // Same-word load on the read edge returns the old word.
    @(negedge clk);
    ce[2] = 1'b1;
    addr  = 32'h4;
    @(posedge clk);
    #1;
    ce[2] = 1'b0;
    check("coll_wait0", obs(2), {3'b010, last_inst[2]});
    @(posedge clk);
    #1;
    check("coll_wait1", obs(2), {3'b010, last_inst[2]});
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
    mem_m[1] = 32'hDEAD_BEEF;
    check("coll_resp", obs(2), {3'b100, 32'h2222_2222});
    last_inst[2] = 32'h2222_2222;
    @(posedge clk);
    #1;
    check("coll_idle", obs(2), {3'b000, last_inst[2]});
    sq = '{32'h4};
    burst(2);

    // Reset during a wait state aborts the fetch and blocks loads.
    @(negedge clk);
    ce[3] = 1'b1;
    addr  = 32'h8;
    @(posedge clk);
    #1;
    ce[3] = 1'b0;
    check("rstmid_wait", obs(3), {3'b010, last_inst[3]});
    @(posedge clk);
    #2;
    rst = 1'b1;
    ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'hBAD0_BAD0;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("rstmid_async_k%0d", k), obs(k), 35'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ld_we = 1'b0;
    for (int k = 0; k < 4; k++) last_inst[k] = 32'h0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("rstmid_nostrobe", obs(3), 35'h0);
    end
    sq = '{32'hC};
    burst(3);

    // Randomized bursts with interleaved loads.
    for (int it = 0; it < 40; it++) begin
      int k;
      int n;
      k = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      sq = {};
      for (int i = 0; i < n; i++) sq.push_back(rand_addr());
      burst(k);
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 1023), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
